// File: rtl/viterbi_hd_k3_decoder.sv
// Hard-decision Viterbi decoder for the rate-1/2, K=3 (7,5 octal) convolutional code.
// Four-state ACS with min-subtract normalization and register-exchange survivors.
module viterbi_hd_k3_decoder #(
  parameter int TB_DEPTH = 8,
  parameter int PM_W     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sym,
  input  logic       sym_valid,
  output logic       dout,
  output logic       dout_valid
);

  localparam int CW = $clog2(TB_DEPTH + 1);

  logic [PM_W-1:0]     pm_reg    [4];
  logic [PM_W-1:0]     pm_next   [4];
  logic [TB_DEPTH-1:0] surv_reg  [4];
  logic [TB_DEPTH-1:0] surv_next [4];
  logic [CW-1:0]       fill_reg;

  logic [PM_W-1:0]     acs       [4];
  logic                sel       [4];
  logic [PM_W-1:0]     pm_min;
  logic [PM_W-1:0]     min01;
  logic [PM_W-1:0]     min23;

  logic [1:0]          best;
  logic                b01;
  logic                b23;
  logic [PM_W-1:0]     v01;
  logic [PM_W-1:0]     v23;

  // Next state gi = {b,p}; predecessors are {p,0} and {p,1}, whose expected
  // symbols are bitwise complements of each other.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_acs
      localparam bit BB = ((gi >> 1) & 1) == 1;
      localparam bit PB = (gi & 1) == 1;
      localparam int P  = gi & 1;
      localparam logic [1:0] EXP0 = {BB ^ PB, BB};

      logic [1:0]      d0;
      logic [1:0]      d1;
      logic [1:0]      bm0;
      logic [1:0]      bm1;
      logic [PM_W-1:0] cand0;
      logic [PM_W-1:0] cand1;

      assign d0    = sym ^ EXP0;
      assign d1    = sym ^ ~EXP0;
      assign bm0   = 2'(d0[1]) + 2'(d0[0]);
      assign bm1   = 2'(d1[1]) + 2'(d1[0]);
      assign cand0 = pm_reg[2*P] + PM_W'(bm0);
      assign cand1 = pm_reg[2*P+1] + PM_W'(bm1);

      // Strict compare so a tie keeps the {p,0} predecessor.
      assign sel[gi] = cand1 < cand0;
      assign acs[gi] = sel[gi] ? cand1 : cand0;
      assign surv_next[gi] = sel[gi] ? {surv_reg[2*P+1][TB_DEPTH-2:0], BB}
                                     : {surv_reg[2*P][TB_DEPTH-2:0], BB};
      assign pm_next[gi] = acs[gi] - pm_min;
    end
  endgenerate

  always_comb begin
    min01  = (acs[1] < acs[0]) ? acs[1] : acs[0];
    min23  = (acs[3] < acs[2]) ? acs[3] : acs[2];
    pm_min = (min23 < min01) ? min23 : min01;
  end

  // Best state from the pre-edge metrics; lower index wins ties.
  always_comb begin
    b01  = pm_reg[1] < pm_reg[0];
    v01  = b01 ? pm_reg[1] : pm_reg[0];
    b23  = pm_reg[3] < pm_reg[2];
    v23  = b23 ? pm_reg[3] : pm_reg[2];
    best = (v23 < v01) ? {1'b1, b23} : {1'b0, b01};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pm_reg[0]  <= '0;
      pm_reg[1]  <= PM_W'(4);
      pm_reg[2]  <= PM_W'(4);
      pm_reg[3]  <= PM_W'(4);
      for (int i = 0; i < 4; i++) begin
        surv_reg[i] <= '0;
      end
      fill_reg   <= '0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      if (sym_valid) begin
        for (int i = 0; i < 4; i++) begin
          pm_reg[i]   <= pm_next[i];
          surv_reg[i] <= surv_next[i];
        end
        if (fill_reg == CW'(TB_DEPTH)) begin
          dout       <= surv_reg[best][TB_DEPTH-1];
          dout_valid <= 1'b1;
        end else begin
          fill_reg <= fill_reg + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_viterbi_hd_k3_decoder.sv
// Bench for viterbi_hd_k3_decoder: directed streams plus randomized traffic
// against a trellis model that decodes by explicit traceback.
module tb_viterbi_hd_k3_decoder;

  localparam int D = 8;

  logic       clk;
  logic       reset;
  logic [1:0] sym;
  logic       sym_valid;
  logic       dout;
  logic       dout_valid;

  int checks;
  int failures;

  int         mpm [4];
  logic [3:0] hist[$];
  int         mfill;
  bit         exp_valid;
  bit         exp_dout;
  int         n_acc;
  int         first_valid;

  bit         msg_q[$];
  bit         got[$];

  viterbi_hd_k3_decoder #(.TB_DEPTH(D), .PM_W(4)) dut (
    .clk(clk), .reset(reset), .sym(sym), .sym_valid(sym_valid),
    .dout(dout), .dout_valid(dout_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] enc_sym(bit b, bit a, bit c);
    return {b ^ a ^ c, b ^ c};
  endfunction

  function automatic int ham(logic [1:0] x, logic [1:0] y);
    logic [1:0] d;
    d = x ^ y;
    return int'(d[0]) + int'(d[1]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    mpm[0] = 0; mpm[1] = 4; mpm[2] = 4; mpm[3] = 4;
    hist.delete();
    mfill = 0;
    exp_valid = 1'b0;
    exp_dout = 1'b0;
    n_acc = 0;
    first_valid = -1;
  endtask

  // Decision is the bit D steps back along the best path, found by traceback.
  task automatic model_accept(input logic [1:0] s);
    int best, st, c0, c1, mn;
    int np[4];
    logic [3:0] dec;
    exp_valid = 1'b0;
    n_acc++;
    if (mfill == D) begin
      best = 0;
      for (int i = 1; i < 4; i++) if (mpm[i] < mpm[best]) best = i;
      st = best;
      for (int t = hist.size() - 1; t >= hist.size() - D; t--) begin
        exp_dout = st[1];
        st = 2 * (st % 2) + int'(hist[t][st]);
      end
      exp_valid = 1'b1;
      if (first_valid < 0) first_valid = n_acc;
    end else begin
      mfill++;
    end
    dec = '0;
    for (int ns = 0; ns < 4; ns++) begin
      c0 = mpm[2 * (ns % 2)]     + ham(s, enc_sym(ns / 2 == 1, ns % 2 == 1, 1'b0));
      c1 = mpm[2 * (ns % 2) + 1] + ham(s, enc_sym(ns / 2 == 1, ns % 2 == 1, 1'b1));
      if (c1 < c0) begin np[ns] = c1; dec[ns] = 1'b1; end
      else         begin np[ns] = c0; dec[ns] = 1'b0; end
    end
    mn = np[0];
    for (int i = 1; i < 4; i++) if (np[i] < mn) mn = np[i];
    for (int i = 0; i < 4; i++) mpm[i] = np[i] - mn;
    hist.push_back(dec);
    if (hist.size() > D) void'(hist.pop_front());
  endtask

  task automatic chk_pm(input string tag);
    for (int i = 0; i < 4; i++) chk($sformatf("%s_pm%0d", tag, i), 32'(dut.pm_reg[i]), 32'(mpm[i]));
  endtask

  task automatic step(input bit v, input logic [1:0] s);
    @(negedge clk);
    sym = s;
    sym_valid = v;
    @(posedge clk);
    #1;
    if (v) model_accept(s);
    else exp_valid = 1'b0;
    chk("dout_valid", 32'(dout_valid), 32'(exp_valid));
    chk("dout", 32'(dout), 32'(exp_dout));
    chk_pm("step");
    if (dout_valid) got.push_back(dout);
    if (v) $display("sym n=%0d sym=%b dout_valid=%b dout=%b", n_acc, s, dout_valid, dout);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      sym = 2'($urandom_range(0, 3));
      sym_valid = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      chk("rst_dout", 32'(dout), 32'd0);
      chk("rst_dout_valid", 32'(dout_valid), 32'd0);
      chk_pm("rst");
    end
    @(negedge clk);
    reset = 1'b0;
    sym_valid = 1'b0;
  endtask

  // Encodes msg_q from state 00, optionally flipping one symbol and inserting a gap.
  task automatic run_stream(input string tag, input int err_at, input logic [1:0] flip,
                            input int gap_after, input int gap_len);
    bit b1, b2;
    logic [1:0] s;
    b1 = 1'b0; b2 = 1'b0;
    got.delete();
    for (int k = 0; k < msg_q.size(); k++) begin
      s = enc_sym(msg_q[k], b1, b2);
      if (k == err_at) s = s ^ flip;
      b2 = b1;
      b1 = msg_q[k];
      step(1'b1, s);
      if (k == gap_after) for (int g = 0; g < gap_len; g++) step(1'b0, 2'($urandom_range(0, 3)));
    end
    chk({tag, "_count"}, 32'(got.size()), 32'(msg_q.size() - D));
    chk({tag, "_first"}, 32'(first_valid), 32'(D + 1));
    for (int i = 0; i < got.size() && i < msg_q.size(); i++)
      chk($sformatf("%s_bit%0d", tag, i), 32'(got[i]), 32'(msg_q[i]));
  endtask

  task automatic std_msg();
    msg_q.delete();
    msg_q.push_back(1); msg_q.push_back(0); msg_q.push_back(1);
    msg_q.push_back(1); msg_q.push_back(0);
    while (msg_q.size() < 20) msg_q.push_back(0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    sym = 2'b00;
    sym_valid = 1'b0;
    model_reset();

    do_reset(5);

    std_msg();
    run_stream("clean", -1, 2'b00, -1, 0);

    do_reset(2);
    run_stream("err1", 2, 2'b10, -1, 0);

    do_reset(2);
    run_stream("gap", -1, 2'b00, 3, 3);

    // Asynchronous reset while output is streaming; the symbol under reset is dropped.
    do_reset(2);
    msg_q.delete();
    for (int i = 0; i < 12; i++) msg_q.push_back(1'($urandom_range(0, 1)));
    got.delete();
    begin
      bit b1, b2;
      b1 = 1'b0; b2 = 1'b0;
      for (int k = 0; k < 12; k++) begin
        step(1'b1, enc_sym(msg_q[k], b1, b2));
        b2 = b1; b1 = msg_q[k];
      end
    end
    chk("pre_rst_valid", 32'(dout_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("async_dout_valid", 32'(dout_valid), 32'd0);
    chk("async_dout", 32'(dout), 32'd0);
    model_reset();
    @(negedge clk);
    sym = 2'b11;
    sym_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_drop_valid", 32'(dout_valid), 32'd0);
    chk_pm("rst_drop");
    @(negedge clk);
    reset = 1'b0;
    sym_valid = 1'b0;
    msg_q.delete();
    for (int i = 0; i < 14; i++) msg_q.push_back(1'($urandom_range(0, 1)));
    for (int i = 0; i < D + 2; i++) msg_q.push_back(0);
    run_stream("restart", -1, 2'b00, -1, 0);

    // Long all-zero run.
    do_reset(1);
    got.delete();
    for (int k = 0; k < 200; k++) step(1'b1, 2'b00);
    chk("zero_pm0", 32'(dut.pm_reg[0]), 32'd0);
    for (int i = 1; i < 4; i++) chk($sformatf("zero_pm%0d_le4", i), 32'(dut.pm_reg[i] <= 4'd4), 32'd1);
    chk("zero_count", 32'(got.size()), 32'(200 - D));
    for (int i = 0; i < got.size(); i++) chk($sformatf("zero_bit%0d", i), 32'(got[i]), 32'd0);

    // Random coded traffic with channel flips and gaps.
    do_reset(1);
    begin
      bit b1, b2, b;
      logic [1:0] s;
      b1 = 1'b0; b2 = 1'b0;
      for (int k = 0; k < 300; k++) begin
        b = 1'($urandom_range(0, 1));
        s = enc_sym(b, b1, b2);
        if ($urandom_range(0, 9) == 0) s = s ^ 2'($urandom_range(1, 3));
        b2 = b1; b1 = b;
        step(1'b1, s);
        if ($urandom_range(0, 4) == 0) step(1'b0, 2'($urandom_range(0, 3)));
      end
    end

    // Arbitrary symbols to exercise metric ties.
    for (int k = 0; k < 150; k++) step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
